// File: rtl/data_sram_bridge.sv
// rtl/data_sram_bridge.sv - CPU data port to SRAM-like bus bridge with one outstanding access
module data_sram_bridge (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        dce,
  input  logic [3:0]  we,
  input  logic [31:0] daddr,
  input  logic [31:0] din,
  input  logic        flush,
  output logic [31:0] dm,
  output logic        stallreq,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] dm_q, dm_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic        xfer_done;
  logic [1:0]  enc_size;
  logic [1:0]  enc_off;
  logic        unused_daddr_lsb;

  // The low address bits come from the byte enables; daddr[1:0] is redundant.
  assign unused_daddr_lsb = ^daddr[1:0];

  always_comb begin
    enc_size = 2'd2;
    enc_off  = 2'b00;
    case (we)
      4'b0011: begin enc_size = 2'd1; enc_off = 2'b00; end
      4'b1100: begin enc_size = 2'd1; enc_off = 2'b10; end
      4'b0001: begin enc_size = 2'd0; enc_off = 2'b00; end
      4'b0010: begin enc_size = 2'd0; enc_off = 2'b01; end
      4'b0100: begin enc_size = 2'd0; enc_off = 2'b10; end
      4'b1000: begin enc_size = 2'd0; enc_off = 2'b11; end
      default: begin enc_size = 2'd2; enc_off = 2'b00; end
    endcase
  end

  assign accept    = (state_q == IDLE) && dce && !flush;
  assign xfer_done = ((state_q == ADDR) && data_addr_ok && data_data_ok) ||
                     ((state_q == DATA) && data_data_ok);

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = ADDR;
      ADDR: begin
        if (data_addr_ok && data_data_ok) begin
          state_d = DONE;
        end else if (data_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: if (data_data_ok) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_req = (state_q == ADDR);
    stallreq = accept || (state_q == ADDR) || (state_q == DATA);
  end

  always_comb begin
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      wr_d    = |we;
      size_d  = enc_size;
      addr_d  = {daddr[31:2], enc_off};
      wdata_d = din;
    end
  end

  // A flush landing on the data_ok cycle itself must also suppress the load.
  always_comb begin
    cancel_d = cancel_q;
    dm_d     = dm_q;
    if (((state_q == ADDR) || (state_q == DATA)) && flush) begin
      cancel_d = 1'b1;
    end
    if (state_q == DONE) begin
      cancel_d = 1'b0;
    end
    if (xfer_done && !wr_q && !cancel_q && !flush) begin
      dm_d = data_rdata;
    end
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      cancel_q <= 1'b0;
      dm_q     <= 32'd0;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      cancel_q <= cancel_d;
      dm_q     <= dm_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign dm         = dm_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// tb/tb_data_sram_bridge.sv - randomized self-checking bench for data_sram_bridge
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        dce;
  logic [3:0]  we;
  logic [31:0] daddr;
  logic [31:0] din;
  logic        flush;
  logic [31:0] dm;
  logic        stallreq;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] data_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] dm_exp;

  data_sram_bridge dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .dce         (dce),
    .we          (we),
    .daddr       (daddr),
    .din         (din),
    .flush       (flush),
    .dm          (dm),
    .stallreq    (stallreq),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(addr_ok),
    .data_data_ok(data_ok),
    .data_rdata  (data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Bus request shape derived from byte-enable population and lowest lane.
  function automatic void model_req(input logic [3:0] w, input logic [31:0] a,
                                    output logic [1:0] sz, output logic [31:0] ad);
    int n;
    int lo;
    n  = $countones(w);
    lo = 0;
    for (int i = 3; i >= 0; i--) if (w[i]) lo = i;
    sz = 2'd2;
    ad = {a[31:2], 2'b00};
    if (n == 1) begin
      sz = 2'd0;
      ad[1:0] = lo[1:0];
    end else if (w == 4'b0011 || w == 4'b1100) begin
      sz = 2'd1;
      ad[1:0] = lo[1:0];
    end
  endfunction

  task automatic run_access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                            input int aw, input int dw, input int fl_cyc, input logic [31:0] rd);
    int req_cnt, stall_cnt, data_left, first_req;
    bit got_ok, cancel;
    logic [1:0]  esz;
    logic [31:0] eaddr;
    model_req(w, a, esz, eaddr);
    req_cnt = 0; stall_cnt = 0; data_left = -1; first_req = -1;
    got_ok = 0; cancel = 0;
    for (int c = 0; c < 64 && !got_ok; c++) begin
      @(negedge clk);
      dce = 1'b1; we = w; daddr = a; din = d;
      addr_ok = 1'b0; data_ok = 1'b0; data_rdata = $urandom;
      flush = (c == fl_cyc);
      if (flush) cancel = 1;
      if (data_req) begin
        req_cnt++;
        if (first_req < 0) begin
          first_req = c;
          chk("req_wr", {31'd0, data_wr}, {31'd0, w != 4'd0});
          chk("req_size", {30'd0, data_size}, {30'd0, esz});
          chk("req_addr", data_addr, eaddr);
          chk("req_wdata", data_wdata, d);
        end
        if (req_cnt == aw + 1) begin
          addr_ok = 1'b1;
          if (dw == 0) data_ok = 1'b1;
          else data_left = dw;
        end
      end else if (data_left > 0) begin
        data_left--;
        if (data_left == 0) data_ok = 1'b1;
      end
      if (data_ok) begin
        data_rdata = rd;
        got_ok = 1;
        chk("hold_addr", data_addr, eaddr);
      end
      #1;
      if (stallreq) stall_cnt++;
    end
    if (!got_ok) chk("timeout", 32'd0, 32'd1);
    chk("first_req_cycle", first_req, 1);
    chk("req_cycles", req_cnt, aw + 1);
    chk("stall_cycles", stall_cnt, aw + dw + 2);
    if (w == 4'd0 && !cancel) dm_exp = rd;
    // DONE: instruction still presented, stray handshakes must be ignored
    @(negedge clk);
    dce = 1'b1; flush = 1'b0;
    addr_ok = 1'($urandom); data_ok = 1'($urandom); data_rdata = $urandom;
    #1;
    chk("done_stall", {31'd0, stallreq}, 32'd0);
    chk("done_req", {31'd0, data_req}, 32'd0);
    chk("dm", dm, dm_exp);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dce = 1'b0; flush = 1'($urandom); we = 4'($urandom); daddr = $urandom;
      addr_ok = 1'($urandom); data_ok = 1'($urandom); data_rdata = $urandom;
      #1;
      chk("idle_stall", {31'd0, stallreq}, 32'd0);
      chk("idle_req", {31'd0, data_req}, 32'd0);
    end
    chk("idle_dm", dm, dm_exp);
  endtask

  initial begin
    rst = 1'b1; dce = 1'b0; we = 4'd0; daddr = 32'd0; din = 32'd0; flush = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; data_rdata = 32'd0;
    dm_exp = 32'd0;
    #12;
    chk("rst_dm", dm, 32'd0);
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_stall", {31'd0, stallreq}, 32'd0);
    chk("rst_wr", {31'd0, data_wr}, 32'd0);
    chk("rst_size", {30'd0, data_size}, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    run_access(4'b0100, 32'h8000_1233, 32'h00AB_0000, 0, 0, -1, 32'h5555_5555);
    idle_cycles(1);
    run_access(4'b0000, 32'h8000_1232, 32'h0, 3, 2, -1, 32'hDEAD_BEEF);
    idle_cycles(2);
    run_access(4'b0000, 32'h8000_1234, 32'h0, 0, 2, 2, 32'h1234_5678);
    idle_cycles(1);
    run_access(4'b0000, 32'h0000_0040, 32'h0, 1, 1, -1, 32'hCAFE_0001);
    run_access(4'b1111, 32'h0000_0044, 32'h0BAD_F00D, 0, 1, -1, 32'h0);
    idle_cycles(1);
    run_access(4'b1100, 32'h0000_0010, 32'h1234_0000, 0, 0, -1, 32'h0);
    idle_cycles(1);
    run_access(4'b0101, 32'h0000_0010, 32'h00FF_00FF, 0, 0, -1, 32'h0);
    idle_cycles(1);
    run_access(4'b0000, 32'h0000_0080, 32'h0, 0, 0, 1, 32'h7777_7777);
    idle_cycles(1);

    // flush with dce in IDLE must not start anything
    @(negedge clk);
    dce = 1'b1; flush = 1'b1; we = 4'd0; addr_ok = 1'b0; data_ok = 1'b0;
    #1;
    chk("flush_idle_stall", {31'd0, stallreq}, 32'd0);
    idle_cycles(1);

    // reset while in ADDR
    @(negedge clk);
    dce = 1'b1; flush = 1'b0; we = 4'd0; daddr = 32'h0000_0100;
    @(negedge clk);
    chk("pre_rst_req", {31'd0, data_req}, 32'd1);
    dce = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_req", {31'd0, data_req}, 32'd0);
    chk("rst_mid_dm", dm, 32'd0);
    chk("rst_mid_stall", {31'd0, stallreq}, 32'd0);
    dm_exp = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    run_access(4'b0000, 32'h0000_0200, 32'h0, 1, 0, -1, 32'hA5A5_5A5A);
    idle_cycles(1);

    for (int k = 0; k < 24; k++) begin
      logic [3:0] w;
      int aw, dw, fl;
      w  = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom);
      aw = $urandom % 4;
      dw = $urandom % 4;
      fl = ($urandom % 3 == 0) ? int'($urandom_range(1, aw + dw + 1)) : -1;
      run_access(w, $urandom, $urandom, aw, dw, fl, $urandom);
      if ($urandom % 2 == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
